// File: rtl/if_id_pipe_buf_if.sv
// IF/ID handshake bundle between fetch, the pipeline buffer and decode.
//   master : the fetch/decode environment around the buffer
//   slave  : the buffer itself
// Signals:
//   in_valid/in_ready/in_pc/in_instr/in_pred_taken : fetch-side entry and handshake
//   flush                                          : squash everything held
//   out_valid/out_ready/out_pc/out_instr/out_pred_taken : decode-side head entry
//   occupancy                                      : entries held, 0..2
interface if_id_pipe_buf_if #(
    parameter int BUS_WIDTH   = 64,
    parameter int INSTR_WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [BUS_WIDTH-1:0]   in_pc;
    logic [INSTR_WIDTH-1:0] in_instr;
    logic                   in_pred_taken;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [BUS_WIDTH-1:0]   out_pc;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic                   out_pred_taken;
    logic [1:0]             occupancy;

    modport master (
        output in_valid, in_pc, in_instr, in_pred_taken, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_pred_taken, occupancy
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_pred_taken, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_pred_taken, occupancy
    );
endinterface

// File: rtl/if_id_pipe_buf.sv
// IF/ID pipeline buffer with valid/ready handshake, 2-entry skid storage,
// flush and NOP bubble insertion on the decode side.
// Ports:
//   clk  : sole clock, posedge
//   rst  : asynchronous active-high reset
//   bus  : if_id_pipe_buf_if.slave (fetch entry in, head entry out, flush,
//          occupancy)
// The main register always holds the oldest entry and drives out_*; the skid
// register holds the younger one while decode stalls. in_ready is a flop so
// fetch never sees a combinational path from out_ready or flush.
module if_id_pipe_buf #(
    parameter int          BUS_WIDTH   = 64,
    parameter int          INSTR_WIDTH = 32,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    if_id_pipe_buf_if.slave    bus
);
    localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(NOP_INSTR);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [BUS_WIDTH-1:0]   pc;
        logic [INSTR_WIDTH-1:0] instr;
        logic                   pt;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_ent;
    logic   in_ready_q;
    logic   push, pop;

    assign in_ent = '{pc: bus.in_pc, instr: bus.in_instr, pt: bus.in_pred_taken};
    assign push   = bus.in_valid & in_ready_q;
    assign pop    = (state_q != EMPTY) & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            // Same-cycle input is dropped; a same-cycle pop was already taken.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        main_d  = in_ent;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_d = TWO;
                        skid_d  = in_ent;
                    end else if (push && pop) begin
                        main_d  = in_ent;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can move us.
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = (state_q != EMPTY);
    assign bus.occupancy      = state_q;
    assign bus.out_pc         = main_q.pc;
    // Bubble insertion: decode sees a NOP with no taken hint when empty.
    assign bus.out_instr      = bus.out_valid ? main_q.instr : NOP;
    assign bus.out_pred_taken = bus.out_valid & main_q.pt;
endmodule

// File: doc/if_id_pipe_buf.md
# if_id_pipe_buf

Parametrised successor to the plain IF/ID pipeline register. It adds a valid/ready handshake, a 2-entry skid buffer, a flush input and bubble (NOP) insertion. The block sits between instruction fetch and decode and carries PC, instruction and a predicted-taken sideband bit. It lets decode stall without a combinational ready path back into fetch, and lets branch resolution squash in-flight fetches.

## Interface
- BUS_WIDTH, 64, PC width in bits
- INSTR_WIDTH, 32, instruction width in bits
- NOP_INSTR, 32'h0000_0013, encoding presented on out_instr whenever out_valid=0; truncated or zero-extended to INSTR_WIDTH
- clk  input  1  sole clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch presents a valid entry
- in_ready  output  1  buffer can accept; registered, depends only on occupancy
- in_pc  input  BUS_WIDTH  fetched PC
- in_instr  input  INSTR_WIDTH  fetched instruction
- in_pred_taken  input  1  branch-predictor taken hint
- flush  input  1  squash all held entries
- out_valid  output  1  out_* hold a valid entry
- out_ready  input  1  decode consumes the entry this cycle
- out_pc  output  BUS_WIDTH  PC of head entry
- out_instr  output  INSTR_WIDTH  instruction of head entry, or NOP_INSTR when invalid
- out_pred_taken  output  1  hint of head entry; 0 when invalid
- occupancy  output  2  number of held entries, 0..2

## Operation
- Storage: main register (drives out_*) and skid register. Each entry is {pc, instr, pred_taken}.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- States: EMPTY (occupancy 0), ONE (1), TWO (2). in_ready = (state != TWO). out_valid = (state != EMPTY).
- EMPTY: push → ONE, main<=in. No push → stay.
- ONE: push & !pop → TWO, skid<=in. push & pop → ONE, main<=in. !push & pop → EMPTY. Neither → hold.
- TWO: no push is possible. pop → ONE, main<=skid. No pop → hold.
- flush: highest priority. Next state is EMPTY regardless of push/pop, and any same-cycle input is discarded. A pop in the flush cycle still counts as consumed by decode.
- When out_valid=0: out_instr=NOP_INSTR, out_pred_taken=0, out_pc holds the last loaded value (0 after reset).
- in_valid with in_ready=0 is ignored. Fetch must hold its data, but the block does not check this.
- Order is strictly preserved: the skid entry is always younger than the main entry.
- occupancy is the state encoding; 3 is unreachable.

## Timing
- Reset (async assert, sync release on clk): state EMPTY, in_ready=1, out_valid=0, out_pc=0, out_instr=NOP_INSTR, out_pred_taken=0, occupancy=0. Skid contents are don't-care.
- Latency: an entry pushed in cycle N appears on out_* with out_valid=1 in cycle N+1 if the buffer was empty or popped in cycle N.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- in_ready is a flop output. There is no combinational path from out_ready or flush to in_ready.
- out_* are flop outputs, except out_instr and out_pred_taken, which are muxed with out_valid.
- When out_ready deasserts with in_valid high: one extra entry is absorbed into skid, then in_ready falls the next cycle.
- When out_ready reasserts from TWO: main<=skid, and in_ready rises the following cycle.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Test plan
- Reset: assert rst asynchronously mid-cycle with the buffer in TWO → outputs go immediately to out_valid=0, out_instr=32'h13, occupancy=0, in_ready=1.
- Streaming: out_ready=1 and push PCs 0x1000, 0x1004, 0x1008 on consecutive cycles → out_pc shows 0x1000, 0x1004, 0x1008 one cycle later, out_valid continuous, occupancy stays 1.
- Stall/skid: buffer in ONE holding 0x2000. Drop out_ready and push 0x2004 → occupancy=2, in_ready=0 next cycle. Raise out_ready → 0x2000 then 0x2004 emerge in order, with no loss or duplication.
- Flush: buffer in TWO, assert flush together with in_valid=1 for 0x3000 → next cycle occupancy=0, out_valid=0, out_instr=NOP, and 0x3000 is never output.
- Backpressure hold: buffer in TWO, out_ready=0 for 5 cycles while in_valid toggles → out_pc and occupancy stay unchanged and in_ready stays 0.
- Sideband: push 0x4000 with in_pred_taken=1 → out_pred_taken=1 while it is the head entry, and 0 once the buffer drains to empty.
